// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage: instruction constants,
// exception cause codes, the default reset PC and the fetch FSM encoding.
package cpu_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0) used for bubbles and exception slots
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch exception causes
  localparam logic [3:0] EXC_INSTR_MISALIGNED   = 4'd0;
  localparam logic [3:0] EXC_INSTR_ACCESS_FAULT = 4'd1;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0000_0000;

  // Fetch FSM encoding
  localparam logic [0:0] FETCH_RUN       = 1'b0;
  localparam logic [0:0] FETCH_TRAP_WAIT = 1'b1;

endpackage

// File: rtl/fetch_stage_if.sv
// IF/ID handshake bundle: fetch (master) produces entries, decode (slave) accepts.
interface fetch_if #(
  parameter int XLEN = 64
);

  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;
  logic            id_exc_en;
  logic [3:0]      id_exc_code;
  logic [XLEN-1:0] id_exc_val;

  modport master (
    output id_valid, id_pc, id_instr, id_exc_en, id_exc_code, id_exc_val,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_pc, id_instr, id_exc_en, id_exc_code, id_exc_val,
    output id_ready
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: one entry with valid/ready handshake and flush.
// Priority: reset > flush > load > drain-on-transfer. Payload is held on flush.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic            exc_en_i,
  input  logic [3:0]      exc_code_i,
  input  logic [XLEN-1:0] exc_val_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            exc_en_o,
  output logic [3:0]      exc_code_o,
  output logic [XLEN-1:0] exc_val_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            exc_en_q, exc_en_d;
  logic [3:0]      exc_code_q, exc_code_d;
  logic [XLEN-1:0] exc_val_q, exc_val_d;

  // Next-entry selection: flush discards, load captures, transfer drains
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    valid_d    = valid_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    exc_en_d   = exc_en_q;
    exc_code_d = exc_code_q;
    exc_val_d  = exc_val_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d    = 1'b1;
      pc_d       = pc_i;
      instr_d    = instr_i;
      exc_en_d   = exc_en_i;
      exc_code_d = exc_code_i;
      exc_val_d  = exc_val_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage with synchronous reset to an empty NOP slot
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignment so all registers update together at the edge.
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= NOP_INSTR;
      exc_en_q   <= 1'b0;
      exc_code_q <= '0;
      exc_val_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      exc_en_q   <= exc_en_d;
      exc_code_q <= exc_code_d;
      exc_val_q  <= exc_val_d;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign instr_o    = instr_q;
  assign exc_en_o   = exc_en_q;
  assign exc_code_o = exc_code_q;
  assign exc_val_o  = exc_val_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory and
// fills the IF/ID register. A fetch exception freezes fetch until redirect.
// Optional macro FETCH_MISALIGN_CHK_EN: raise a misaligned-fetch exception
// when pc_q[1:0] != 0 (takes priority over the memory's exception).
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [XLEN-1:0]  imem_pc_addr,
  input  logic [31:0]      imem_instruction,
  input  logic             imem_exc_en,
  input  logic [3:0]       imem_exc_code,
  input  logic [XLEN-1:0]  imem_exc_val,
  input  logic             redirect_en,
  input  logic [XLEN-1:0]  redirect_pc,
  fetch_if.master          id
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [0:0]      state_q, state_d;

  logic            load;
  logic            exc_hit;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_val;
  logic [31:0]     load_instr;

  assign imem_pc_addr = pc_q;
  assign load = (state_q == FETCH_RUN) && (!id.id_valid || id.id_ready);

  // Fetch exception source for the current PC
  always_comb begin
`ifdef FETCH_MISALIGN_CHK_EN
    if (pc_q[1:0] != 2'b00) begin
      exc_hit  = 1'b1;
      exc_code = EXC_INSTR_MISALIGNED;
      exc_val  = pc_q;
    end else begin
      exc_hit  = imem_exc_en;
      exc_code = imem_exc_code;
      exc_val  = imem_exc_val;
    end
`else
    exc_hit  = imem_exc_en;
    exc_code = imem_exc_code;
    exc_val  = imem_exc_val;
`endif
  end

  assign load_instr = exc_hit ? NOP_INSTR : imem_instruction;

  // PC and FSM next state: redirect > load (advance or trap)
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_en) begin
      pc_d    = redirect_pc;
      state_d = FETCH_RUN;
    end else if (load) begin
      if (exc_hit) state_d = FETCH_TRAP_WAIT;
      else         pc_d    = pc_q + XLEN'(4);
    end
  end

  // PC and FSM registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= FETCH_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  if_id_reg #(.XLEN(XLEN)) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect_en),
    .load_i     (load),
    .pc_i       (pc_q),
    .instr_i    (load_instr),
    .exc_en_i   (exc_hit),
    .exc_code_i (exc_code),
    .exc_val_i  (exc_val),
    .ready_i    (id.id_ready),
    .valid_o    (id.id_valid),
    .pc_o       (id.id_pc),
    .instr_o    (id.id_instr),
    .exc_en_o   (id.id_exc_en),
    .exc_code_o (id.id_exc_code),
    .exc_val_o  (id.id_exc_val)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage. Each vector drives inputs on
// the falling edge and checks the registered state 1 time unit after the
// following rising edge. Instruction memory is a small combinational model.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] imem_pc_addr;
  logic [31:0] imem_instruction;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_en;
  logic [63:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  fetch_if #(.XLEN(64)) id_bus ();

  fetch_stage #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_pc_addr     (imem_pc_addr),
    .imem_instruction (imem_instruction),
    .imem_exc_en      (imem_exc_en),
    .imem_exc_code    (imem_exc_code),
    .imem_exc_val     (imem_exc_val),
    .redirect_en      (redirect_en),
    .redirect_pc      (redirect_pc),
    .id               (id_bus.master)
  );

  always #5 clk = ~clk;

  // Memory contents: two fixed words at 0/4, otherwise {addr[23:0], 8'h13}
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0)      return 32'h0050_0093;
    else if (a == 64'h4) return 32'h0010_0113;
    else                 return {a[23:0], 8'h13};
  endfunction

  always_comb imem_instruction = mem_word(imem_pc_addr);

  typedef struct {
    logic        rst_n;
    logic        redir;
    logic [63:0] redir_pc;
    logic        ready;
    logic        mexc;
    logic [3:0]  mcode;
    logic [63:0] mval;
    logic        chk_data;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic        e_exc;
    logic [3:0]  e_code;
    logic [63:0] e_val;
    logic [63:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  // Drive: rst_n, redirect, redirect_pc, ready, mem exc/code/val.
  // Expect: check payload?, valid, id_pc, id_instr, exc, code, val, imem addr.
  function automatic void add(
      input logic r, input logic rd, input logic [63:0] rpc, input logic rdy,
      input logic me, input logic [3:0] mc, input logic [63:0] mv,
      input logic cd, input logic ev, input logic [63:0] ep, input logic [31:0] ei,
      input logic ee, input logic [3:0] ec, input logic [63:0] eval, input logic [63:0] ea);
    vec_t v;
    v.rst_n = r;  v.redir = rd; v.redir_pc = rpc; v.ready = rdy;
    v.mexc = me;  v.mcode = mc; v.mval = mv;
    v.chk_data = cd; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
    v.e_exc = ee; v.e_code = ec; v.e_val = eval; v.e_addr = ea;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic [63:0] rpc,
                       input logic rdy, input logic me, input logic [3:0] mc,
                       input logic [63:0] mv);
    rst_n = r; redirect_en = rd; redirect_pc = rpc;
    id_bus.id_ready = rdy; imem_exc_en = me; imem_exc_code = mc; imem_exc_val = mv;
  endtask

  task automatic check_outputs(input string tag, input logic cd, input logic ev,
                               input logic [63:0] ep, input logic [31:0] ei,
                               input logic ee, input logic [3:0] ec,
                               input logic [63:0] eval, input logic [63:0] ea);
    check({tag, " id_valid"}, 64'(id_bus.id_valid), 64'(ev));
    check({tag, " imem_pc_addr"}, imem_pc_addr, ea);
    if (cd) begin
      check({tag, " id_pc"}, id_bus.id_pc, ep);
      check({tag, " id_instr"}, 64'(id_bus.id_instr), 64'(ei));
      check({tag, " id_exc_en"}, 64'(id_bus.id_exc_en), 64'(ee));
      check({tag, " id_exc_code"}, 64'(id_bus.id_exc_code), 64'(ec));
      check({tag, " id_exc_val"}, id_bus.id_exc_val, eval);
    end
  endtask

  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 4'd0, 64'h0);

    //   rst rd  rpc      rdy me mc   mval      cd ev  id_pc    id_instr      ee ec   eval      addr
    add(0, 0, 64'h0,    0, 0, 4'd0, 64'h0,    1, 0, 64'h0,    NOP_INSTR,    0, 4'd0, 64'h0,    64'h0);     // reset
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    1, 1, 64'h0,    32'h00500093, 0, 4'd0, 64'h0,    64'h4);     // first fetch
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    1, 1, 64'h4,    32'h00100113, 0, 4'd0, 64'h0,    64'h8);     // back-to-back
    add(1, 0, 64'h0,    0, 0, 4'd0, 64'h0,    1, 1, 64'h4,    32'h00100113, 0, 4'd0, 64'h0,    64'h8);     // stall 1
    add(1, 0, 64'h0,    0, 0, 4'd0, 64'h0,    1, 1, 64'h4,    32'h00100113, 0, 4'd0, 64'h0,    64'h8);     // stall 2
    add(1, 0, 64'h0,    0, 0, 4'd0, 64'h0,    1, 1, 64'h4,    32'h00100113, 0, 4'd0, 64'h0,    64'h8);     // stall 3
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    1, 1, 64'h8,    32'h00000813, 0, 4'd0, 64'h0,    64'hC);     // resume
    add(1, 1, 64'h100,  1, 0, 4'd0, 64'h0,    0, 0, 64'h0,    32'h0,        0, 4'd0, 64'h0,    64'h100);   // redirect bubble
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    1, 1, 64'h100,  32'h00010013, 0, 4'd0, 64'h0,    64'h104);   // fetch at target
    add(1, 1, 64'h2000, 1, 0, 4'd0, 64'h0,    0, 0, 64'h0,    32'h0,        0, 4'd0, 64'h0,    64'h2000);
    add(1, 0, 64'h0,    1, 1, 4'd1, 64'h2000, 1, 1, 64'h2000, NOP_INSTR,    1, 4'd1, 64'h2000, 64'h2000);  // access fault
    add(1, 0, 64'h0,    0, 0, 4'd0, 64'h0,    1, 1, 64'h2000, NOP_INSTR,    1, 4'd1, 64'h2000, 64'h2000);  // held exc entry
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    0, 0, 64'h0,    32'h0,        0, 4'd0, 64'h0,    64'h2000);  // drains
    add(1, 0, 64'h0,    1, 1, 4'd1, 64'h2000, 0, 0, 64'h0,    32'h0,        0, 4'd0, 64'h0,    64'h2000);  // mem exc ignored
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    0, 0, 64'h0,    32'h0,        0, 4'd0, 64'h0,    64'h2000);
    add(1, 1, 64'h80,   1, 1, 4'd1, 64'h2000, 0, 0, 64'h0,    32'h0,        0, 4'd0, 64'h0,    64'h80);    // leave trap
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    1, 1, 64'h80,   32'h00008013, 0, 4'd0, 64'h0,    64'h84);
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    1, 1, 64'h84,   32'h00008413, 0, 4'd0, 64'h0,    64'h88);
    add(1, 1, 64'h3C,   1, 0, 4'd0, 64'h0,    0, 0, 64'h0,    32'h0,        0, 4'd0, 64'h0,    64'h3C);
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    1, 1, 64'h3C,   32'h00003C13, 0, 4'd0, 64'h0,    64'h40);    // pc=0x40, valid
    add(0, 1, 64'h500,  1, 0, 4'd0, 64'h0,    1, 0, 64'h0,    NOP_INSTR,    0, 4'd0, 64'h0,    64'h0);     // reset beats redirect
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    1, 1, 64'h0,    32'h00500093, 0, 4'd0, 64'h0,    64'h4);
    add(1, 1, 64'h102,  1, 0, 4'd0, 64'h0,    0, 0, 64'h0,    32'h0,        0, 4'd0, 64'h0,    64'h102);
`ifdef FETCH_MISALIGN_CHK_EN
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    1, 1, 64'h102,  NOP_INSTR,    1, EXC_INSTR_MISALIGNED, 64'h102, 64'h102);
`else
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    1, 1, 64'h102,  32'h00010213, 0, 4'd0, 64'h0,    64'h106);
`endif
    add(1, 1, TOP,      1, 0, 4'd0, 64'h0,    0, 0, 64'h0,    32'h0,        0, 4'd0, 64'h0,    TOP);
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    1, 1, TOP,      32'hFFFFFC13, 0, 4'd0, 64'h0,    64'h0);     // PC wraps
    add(1, 0, 64'h0,    0, 0, 4'd0, 64'h0,    1, 1, TOP,      32'hFFFFFC13, 0, 4'd0, 64'h0,    64'h0);
    add(1, 0, 64'h0,    1, 0, 4'd0, 64'h0,    1, 1, 64'h0,    32'h00500093, 0, 4'd0, 64'h0,    64'h4);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].redir, vecs[i].redir_pc, vecs[i].ready,
            vecs[i].mexc, vecs[i].mcode, vecs[i].mval);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].chk_data, vecs[i].e_valid,
                    vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_exc, vecs[i].e_code,
                    vecs[i].e_val, vecs[i].e_addr);
    end

    // Hand sequence: two redirects back to back, the later target wins
    @(negedge clk);
    drive(1'b1, 1'b1, 64'h200, 1'b1, 1'b0, 4'd0, 64'h0);
    @(posedge clk); #1;
    check_outputs("redir_a", 1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 4'd0, 64'h0, 64'h200);
    @(negedge clk);
    drive(1'b1, 1'b1, 64'h300, 1'b1, 1'b0, 4'd0, 64'h0);
    @(posedge clk); #1;
    check_outputs("redir_b", 1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 4'd0, 64'h0, 64'h300);
    @(negedge clk);
    drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 4'd0, 64'h0);
    @(posedge clk); #1;
    check_outputs("redir_c", 1'b1, 1'b1, 64'h300, 32'h00030013, 1'b0, 4'd0, 64'h0, 64'h304);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction memory.
- Owns the PC register and drives the memory address.
- Captures the returned instruction and any fetch exception into a registered IF/ID output with valid/ready handshake toward decode.
- Handles redirects (branch, jump, trap vector) and freezes fetch after a fetch exception until redirected.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC value loaded on reset.
- XLEN, 64, PC and exception-value width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- imem_pc_addr  output  XLEN  fetch address to instruction memory; equals pc_q combinationally.
- imem_instruction  input  32  instruction returned for imem_pc_addr, same cycle.
- imem_exc_en  input  1  fetch exception flag from memory.
- imem_exc_code  input  4  fetch exception cause.
- imem_exc_val  input  XLEN  fetch exception value (bad PC).
- redirect_en  input  1  flush and redirect request from execute/trap logic.
- redirect_pc  input  XLEN  target PC for a redirect.
- id_ready  input  1  decode accepts the IF/ID entry this cycle.
- id_valid  output  1  IF/ID entry valid.
- id_pc  output  XLEN  PC of the IF/ID instruction.
- id_instr  output  32  IF/ID instruction word.
- id_exc_en  output  1  IF/ID entry carries a fetch exception.
- id_exc_code  output  4  cause for id_exc_en.
- id_exc_val  output  XLEN  mtval for id_exc_en.

Behaviour:
- Reset
  - rst_n low at a clk edge: pc_q=RESET_PC, state=RUN, id_valid=0, id_instr=32'h00000013, id_pc=0, id_exc_en=0, id_exc_code=0, id_exc_val=0.
  - Reset overrides redirect and handshake; reset mid-operation discards the IF/ID entry.
- Handshake
  - transfer = id_valid & id_ready.
  - load = (state==RUN) & (!id_valid | id_ready).
  - Entry is held stable while id_valid & !id_ready.
- Priority per edge: reset > redirect > load.
- Redirect (redirect_en=1)
  - pc_q<=redirect_pc; id_valid<=0, discarding the entry even if transfer occurs the same cycle; state<=RUN.
  - Next fetch occurs from redirect_pc one cycle later (1-cycle bubble).
- State RUN, load with imem_exc_en=0
  - id_valid<=1, id_pc<=pc_q, id_instr<=imem_instruction, exception fields cleared.
  - pc_q<=pc_q+4, modulo 2^XLEN (64'hFFFF_FFFF_FFFF_FFFC wraps to 0).
- State RUN, load with imem_exc_en=1
  - id_valid<=1, id_instr<=32'h00000013, id_exc_en<=1, code/val copied from memory.
  - pc_q held; state<=TRAP_WAIT.
- State RUN, no load: all registers hold.
- State TRAP_WAIT
  - No loads; pc_q held; exception entry drains on transfer (id_valid<=0).
  - Leaves only via redirect.
  - imem exception outputs are ignored here: memory exc_en alternates on a held out-of-range PC and must not retrigger.
- Latency: PC to id_valid is 1 cycle; sustained throughput is 1 instruction/cycle when id_ready=1.
- id_ready while id_valid=0 is ignored.

Optional Feature:
- FETCH_MISALIGN_CHK_EN defined
  - In RUN, pc_q[1:0]!=0 raises a local exception: code 4'd0, val=pc_q, id_instr=NOP, state<=TRAP_WAIT.
  - Takes priority over imem_exc_en; memory data is ignored.
- Undefined: pc_q[1:0] is not checked; the memory ignores the low bits.

Decomposition:
- Shared cpu_pkg holds:
  - NOP_INSTR=32'h00000013
  - EXC_INSTR_MISALIGNED=4'd0, EXC_INSTR_ACCESS_FAULT=4'd1
  - default RESET_PC
  - fetch state encoding (RUN, TRAP_WAIT)
- Sub-module if_id_reg: the valid/ready holding register with flush input. PC logic and the FSM stay in fetch_stage.

Test Plan:
- Reset with RESET_PC=0, id_ready=1, memory returns 0x00500093 then 0x00100113 -> id_pc 0x0/0x4 on consecutive cycles; imem_pc_addr 0x0,0x4,0x8.
- id_ready=0 for 3 cycles with id_valid=1 -> id_pc/id_instr stable, pc_q frozen; on release, resumes with no loss or duplicate.
- redirect_en=1, redirect_pc=0x100 while id_valid=1, id_ready=1 -> next cycle id_valid=0; following cycle id_pc=0x100.
- imem_exc_en=1, code=1, val=0x2000 at pc 0x2000 -> id_exc_en=1, id_instr=0x00000013, pc stays 0x2000. Alternating memory exc_en is ignored until redirect to 0x80; fetch then resumes at 0x80.
- rst_n low for one edge mid-stream (pc=0x40, id_valid=1) -> id_valid=0, pc=RESET_PC next cycle; simultaneous redirect is ignored.
- With FETCH_MISALIGN_CHK_EN, redirect_pc=0x102 -> id_exc_en=1, code 0, val 0x102; without the macro -> normal fetch at 0x102.
